// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared forwarding selects, hazard FSM states and bubble convention
package hazard_pkg;

   localparam logic [1:0] FWD_RF    = 2'b00;
   localparam logic [1:0] FWD_EXMEM = 2'b10;
   localparam logic [1:0] FWD_MEMWB = 2'b01;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      LDSTALL = 2'd1,
      FLUSH   = 2'd2
   } hzState_e;

   // ID/EX loads all-zero control (a NOP) whenever idex_bubble carries this level
   localparam logic BUBBLE_ON = 1'b1;

endpackage

// File: rtl/fwd_src_sel.sv
// rtl/fwd_src_sel.sv - single-source comparator with EX/MEM over MEM/WB priority
module fwd_src_sel
   import hazard_pkg::*;
#(
   parameter int AW          = 4,
   parameter int ZERO_REG_EN = 1
) (
   input  logic [AW-1:0] srcAddr,
   input  logic          srcVld,
   input  logic [AW-1:0] memRd,
   input  logic          memRegwrite,
   input  logic [AW-1:0] wbRd,
   input  logic          wbRegwrite,
   output logic [1:0]    sel
);

   logic zeroSrc;

   assign zeroSrc = (ZERO_REG_EN != 0) && (srcAddr == '0);

   always_comb begin
      sel = FWD_RF;
      if (srcVld && !zeroSrc) begin
         if (memRegwrite && (memRd == srcAddr)) begin
            sel = FWD_EXMEM;
         end else if (wbRegwrite && (wbRd == srcAddr)) begin
            sel = FWD_MEMWB;
         end
      end
   end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - operand forwarding, load-use stall and branch flush control
module hazard_fwd_unit
   import hazard_pkg::*;
#(
   parameter int AW          = 4,
   parameter int NUM_SRC     = 2,
   parameter int ZERO_REG_EN = 1,
   parameter int LU_CYCLES   = 1,
   parameter int CNT_W       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_SRC*AW-1:0] id_src_addr,
   input  logic [NUM_SRC-1:0]    id_src_vld,
   input  logic [NUM_SRC*AW-1:0] ex_src_addr,
   input  logic [NUM_SRC-1:0]    ex_src_vld,
   input  logic [AW-1:0]         ex_rd,
   input  logic                  ex_regwrite,
   input  logic                  ex_memread,
   input  logic [AW-1:0]         mem_rd,
   input  logic                  mem_regwrite,
   input  logic [AW-1:0]         wb_rd,
   input  logic                  wb_regwrite,
   input  logic                  br_taken,
   input  logic                  cnt_clr,
   output logic [2*NUM_SRC-1:0]  fwd_sel,
   output logic                  pc_stall,
   output logic                  ifid_stall,
   output logic                  idex_bubble,
   output logic                  ifid_flush,
   output logic [CNT_W-1:0]      stall_cnt,
   output logic [CNT_W-1:0]      flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   hzState_e   state, stateNxt;
   logic [2:0] luCnt, luCntNxt;
   logic       luHit;
   logic       stallReq, bubbleReq, flushReq;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SRC; gi++) begin : gSrc
         fwd_src_sel #(
            .AW          (AW),
            .ZERO_REG_EN (ZERO_REG_EN)
         ) uSel (
            .srcAddr     (ex_src_addr[gi*AW +: AW]),
            .srcVld      (ex_src_vld[gi]),
            .memRd       (mem_rd),
            .memRegwrite (mem_regwrite),
            .wbRd        (wb_rd),
            .wbRegwrite  (wb_regwrite),
            .sel         (fwd_sel[2*gi +: 2])
         );
      end
   endgenerate

   always_comb begin
      luHit = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (id_src_vld[k] && (id_src_addr[k*AW +: AW] == ex_rd)) begin
            luHit = 1'b1;
         end
      end
      if ((ZERO_REG_EN != 0) && (ex_rd == '0)) begin
         luHit = 1'b0;
      end
      luHit = luHit && ex_regwrite && ex_memread;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         luCnt <= '0;
      end else begin
         state <= stateNxt;
         luCnt <= luCntNxt;
      end
   end

   // A taken branch overrides everything, including the stall it interrupts
   always_comb begin
      stateNxt  = state;
      luCntNxt  = luCnt;
      stallReq  = 1'b0;
      bubbleReq = 1'b0;
      flushReq  = 1'b0;
      if (br_taken) begin
         flushReq  = 1'b1;
         bubbleReq = BUBBLE_ON;
         stateNxt  = FLUSH;
         luCntNxt  = '0;
      end else begin
         case (state)
            RUN: begin
               if (luHit) begin
                  stallReq  = 1'b1;
                  bubbleReq = BUBBLE_ON;
                  if (LU_CYCLES > 1) begin
                     stateNxt = LDSTALL;
                     luCntNxt = 3'(LU_CYCLES - 1);
                  end
               end
            end
            LDSTALL: begin
               stallReq  = 1'b1;
               bubbleReq = BUBBLE_ON;
               if (luCnt <= 3'd1) begin
                  stateNxt = RUN;
                  luCntNxt = '0;
               end else begin
                  luCntNxt = luCnt - 3'd1;
               end
            end
            FLUSH: begin
               bubbleReq = BUBBLE_ON;
               stateNxt  = RUN;
            end
            default: begin
               stateNxt = RUN;
               luCntNxt = '0;
            end
         endcase
      end
   end

   assign pc_stall    = rst_n & stallReq;
   assign ifid_stall  = rst_n & stallReq;
   assign idex_bubble = rst_n & bubbleReq;
   assign ifid_flush  = rst_n & flushReq;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (cnt_clr) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stallReq && (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
         if (br_taken && (flush_cnt != CNT_MAX)) begin
            flush_cnt <= flush_cnt + CNT_W'(1);
         end
      end
   end

endmodule
